ncl_wavefront_sequencer: RTL and testbench

//  Clocked controller that sequences one NCL dual-rail stage (threshold-gate

---
 rtl/ncl_wavefront_sequencer.sv | 144 ++++++++++++++
 tb/tb_ncl_wavefront_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ncl_wavefront_sequencer.sv
// Sequences one NCL dual-rail stage through DATA then NULL wavefronts and returns
// the captured result as a single-cycle response, with a timeout and illegal-encoding error.
module ncl_wavefront_sequencer #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  output logic [WIDTH-1:0] dr_t,
  output logic [WIDTH-1:0] dr_f,
  input  logic             ko,
  input  logic [WIDTH-1:0] res_t,
  input  logic [WIDTH-1:0] res_f,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_error,
  output logic             busy
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_NULL, S_RESP} state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] dr_t_q, dr_t_d, dr_f_q, dr_f_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic [SYNC_STAGES-1:0] ko_sr_q;
  logic [WIDTH-1:0]       rt_sr_q [SYNC_STAGES];
  logic [WIDTH-1:0]       rf_sr_q [SYNC_STAGES];
  logic                   ko_s;
  logic [WIDTH-1:0]       rt_s, rf_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ko_sr_q <= '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        rt_sr_q[i] <= '0;
        rf_sr_q[i] <= '0;
      end
    end else begin
      ko_sr_q    <= {ko_sr_q[SYNC_STAGES-2:0], ko};
      rt_sr_q[0] <= res_t;
      rf_sr_q[0] <= res_f;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        rt_sr_q[i] <= rt_sr_q[i-1];
        rf_sr_q[i] <= rf_sr_q[i-1];
      end
    end
  end

  assign ko_s = ko_sr_q[SYNC_STAGES-1];
  assign rt_s = rt_sr_q[SYNC_STAGES-1];
  assign rf_s = rf_sr_q[SYNC_STAGES-1];

  logic all_complete, all_null, any_illegal, timer_hit;
  assign all_complete = &(rt_s ^ rf_s);
  assign all_null     = ~|(rt_s | rf_s);
  assign any_illegal  = |(rt_s & rf_s);
  assign timer_hit    = (timer_q == TLAST);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    err_d      = err_q;
    dr_t_d     = dr_t_q;
    dr_f_d     = dr_f_q;
    rsp_data_d = rsp_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && ko_s) begin
          dr_t_d  = req_data;
          dr_f_d  = ~req_data;
          timer_d = '0;
          err_d   = 1'b0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        timer_d = timer_q + 1'b1;
        if (any_illegal) err_d = 1'b1;
        // Completion is checked before the timer so a same-cycle exit carries no timeout error.
        if (!ko_s && all_complete) begin
          rsp_data_d = rt_s;
          dr_t_d     = '0;
          dr_f_d     = '0;
          timer_d    = '0;
          state_d    = S_NULL;
        end else if (timer_hit) begin
          dr_t_d  = '0;
          dr_f_d  = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_NULL: begin
        timer_d = timer_q + 1'b1;
        if (any_illegal) err_d = 1'b1;
        if (ko_s && all_null) begin
          state_d = S_RESP;
        end else if (timer_hit) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      err_q      <= 1'b0;
      dr_t_q     <= '0;
      dr_f_q     <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      err_q      <= err_d;
      dr_t_q     <= dr_t_d;
      dr_f_q     <= dr_f_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign dr_t      = dr_t_q;
  assign dr_f      = dr_f_q;
  assign rsp_data  = rsp_data_q;
  assign req_ready = (state_q == S_IDLE) && ko_s;
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_error = rsp_valid && err_q;

endmodule

// File: tb/tb_ncl_wavefront_sequencer.sv
// Bench for ncl_wavefront_sequencer: a delay-line NCL stage model (identity or inverting)
// drives a table of directed transactions, corner-case sequences and randomized traffic.
module tb_ncl_wavefront_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_data = '0;
  logic [3:0] dr_t, dr_f;
  logic       ko;
  logic [3:0] res_t, res_f;
  logic       rsp_valid;
  logic [3:0] rsp_data;
  logic       rsp_error;
  logic       busy;

  ncl_wavefront_sequencer #(
    .WIDTH(4),
    .TIMEOUT(16),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .dr_t(dr_t), .dr_f(dr_f), .ko(ko), .res_t(res_t), .res_f(res_f),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int rsp_cnt = 0;

  // Stage model: result rails are the driven rails delayed by d cycles, optionally
  // inverted (rail swap); ko drops once the result is a complete DATA word.
  int         d = 3;
  bit         inv = 1'b0;
  bit         ko_f1 = 1'b0;
  bit         ko_f0 = 1'b0;
  bit         inj = 1'b0;
  logic [3:0] pt [8];
  logic [3:0] pf [8];
  logic [3:0] base_t, base_f, st, sf;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        pt[i] <= '0;
        pf[i] <= '0;
      end
    end else begin
      pt[0] <= dr_t;
      pf[0] <= dr_f;
      for (int i = 1; i < 8; i++) begin
        pt[i] <= pt[i-1];
        pf[i] <= pf[i-1];
      end
    end
  end

  always_comb begin
    st = dr_t;
    sf = dr_f;
    if (d > 0) begin
      st = pt[d-1];
      sf = pf[d-1];
    end
    base_t = inv ? sf : st;
    base_f = inv ? st : sf;
    ko     = ko_f1 ? 1'b1 : (ko_f0 ? 1'b0 : ~&(base_t ^ base_f));
    res_t  = base_t | {1'b0, inj, 2'b00};
    res_f  = base_f | {1'b0, inj, 2'b00};
  end

  always @(posedge clk) if (rsp_valid) rsp_cnt <= rsp_cnt + 1;

  always @(negedge clk) begin
    tests++;
    if ((dr_t & dr_f) != 4'h0) begin
      fails++;
      $display("FAIL rail_exclusive: dr_t=%b dr_f=%b required no common 1", dr_t, dr_f);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_stage(input int nd, input bit ninv);
    repeat (6) @(negedge clk);
    d   = nd;
    inv = ninv;
  endtask

  task automatic run_txn(input logic [3:0] r, input logic [3:0] exp_d, input bit exp_e,
                         input int exp_lat, input int inj_at);
    int         n;
    bit         got;
    bit         rdy;
    logic [3:0] nr;
    nr = ~r;
    @(negedge clk);
    req_valid = 1'b1;
    req_data  = r;
    rdy = 1'b0;
    for (int k = 0; k < 60 && !rdy; k++) begin
      if (req_ready) rdy = 1'b1;
      else @(negedge clk);
    end
    check("accept_ready", {31'b0, rdy}, 32'd1);
    if (!rdy) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_data  = 4'($urandom);
    n   = 0;
    got = 1'b0;
    while (!got && n < 64) begin
      @(negedge clk);
      if (n == 0) begin
        check("data_rail_t", {28'b0, dr_t}, {28'b0, r});
        check("data_rail_f", {28'b0, dr_f}, {28'b0, nr});
      end
      if (inj_at >= 0 && n == inj_at) inj = 1'b1;
      if (inj_at >= 0 && n == inj_at + 1) inj = 1'b0;
      if (rsp_valid) got = 1'b1;
      else begin
        @(posedge clk);
        n++;
      end
    end
    inj = 1'b0;
    check("rsp_seen", {31'b0, got}, 32'd1);
    check("latency", n, exp_lat);
    check("rsp_data", {28'b0, rsp_data}, {28'b0, exp_d});
    check("rsp_error", {31'b0, rsp_error}, {31'b0, exp_e});
    check("rails_null_at_rsp", {28'b0, dr_t | dr_f}, 32'd0);
    @(negedge clk);
    check("rsp_one_cycle", {31'b0, rsp_valid}, 32'd0);
    check("rsp_data_held", {28'b0, rsp_data}, {28'b0, exp_d});
    check("idle_after_rsp", {31'b0, busy}, 32'd0);
  endtask

  typedef struct {
    logic [3:0] req;
    bit         inv;
    int         d;
    logic [3:0] exp_data;
    bit         exp_err;
    int         exp_lat;
  } vec_t;

  vec_t       tbl [6];
  logic [3:0] last;
  logic [3:0] r, e;
  int         cnt0;

  initial begin
    tbl[0] = '{4'hA, 1'b0, 3, 4'hA, 1'b0, 12};
    tbl[1] = '{4'h3, 1'b1, 3, 4'hC, 1'b0, 12};
    tbl[2] = '{4'h5, 1'b1, 3, 4'hA, 1'b0, 12};
    tbl[3] = '{4'hF, 1'b0, 0, 4'hF, 1'b0, 6};
    tbl[4] = '{4'h6, 1'b1, 1, 4'h9, 1'b0, 8};
    tbl[5] = '{4'h0, 1'b0, 4, 4'h0, 1'b0, 14};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dr_t", {28'b0, dr_t}, 32'd0);
    check("rst_dr_f", {28'b0, dr_f}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_error", {31'b0, rsp_error}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_rsp_data", {28'b0, rsp_data}, 32'd0);
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_before_sync", {31'b0, req_ready}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      set_stage(tbl[i].d, tbl[i].inv);
      run_txn(tbl[i].req, tbl[i].exp_data, tbl[i].exp_err, tbl[i].exp_lat, -1);
    end
    last = 4'h0;

    // ko stuck at 1: DATA times out after TIMEOUT cycles, rsp_data keeps previous value
    set_stage(3, 1'b0);
    ko_f1 = 1'b1;
    run_txn(4'h9, last, 1'b1, 16, -1);
    check("ready_after_timeout", {31'b0, req_ready}, 32'd1);
    ko_f1 = 1'b0;

    // one-cycle illegal encoding on bit 2 while DATA is in flight
    set_stage(5, 1'b0);
    run_txn(4'h7, 4'h7, 1'b1, 16, 2);
    last = 4'h7;

    // reset during NULL phase aborts silently
    set_stage(3, 1'b0);
    @(negedge clk);
    req_valid = 1'b1;
    req_data  = 4'hB;
    for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("in_null_busy", {31'b0, busy}, 32'd1);
    check("in_null_rails", {28'b0, dr_t | dr_f}, 32'd0);
    cnt0 = rsp_cnt;
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_rails", {28'b0, dr_t | dr_f}, 32'd0);
    check("rst_mid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("no_rsp_after_abort", rsp_cnt, cnt0);
    last = 4'h0;
    run_txn(4'hF, 4'hF, 1'b0, 12, -1);
    last = 4'hF;

    // ko low in IDLE blocks acceptance even with req_valid held
    set_stage(2, 1'b0);
    ko_f0 = 1'b1;
    repeat (4) @(negedge clk);
    req_valid = 1'b1;
    req_data  = 4'h6;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("ko_low_not_ready", {31'b0, req_ready}, 32'd0);
      check("ko_low_not_busy", {31'b0, busy}, 32'd0);
    end
    ko_f0 = 1'b0;
    run_txn(4'h6, 4'h6, 1'b0, 10, -1);
    last = 4'h6;

    // randomized traffic against the stage-function model
    for (int t = 0; t < 40; t++) begin
      r = 4'($urandom);
      if ($urandom_range(7) == 0) begin
        ko_f1 = 1'b1;
        repeat (3) @(negedge clk);
        run_txn(r, last, 1'b1, 16, -1);
        ko_f1 = 1'b0;
        repeat (10) @(negedge clk);
      end else begin
        set_stage(int'($urandom_range(4)), bit'($urandom_range(1)));
        e = inv ? ~r : r;
        run_txn(r, e, 1'b0, 2 * d + 6, -1);
        last = e;
        repeat ($urandom_range(3)) @(negedge clk);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
